image_serializer: RTL

//  Transmit-side counterpart of the 32-bit image deserializer.

---
 rtl/image_serializer.sv | 94 +++++++++
 1 files changed

// File: rtl/image_serializer.sv
// Frame-to-stream serializer: captures one DEPTH-bit frame and emits it as 32-bit
// words on a valid/ready master port, most significant word first.
module image_serializer #(
    parameter int DEPTH  = 128,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_collision_state,
    input  logic              frame_valid,
    input  logic [DEPTH-1:0]  frame_data,
    output logic              frame_ready,
    output logic [WORD_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frames_sent
);

    localparam int NUM_WORDS = DEPTH / WORD_W;
    localparam int CNT_W     = $clog2(NUM_WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DEPTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [15:0]        frames_sent_q, frames_sent_d;
    logic               frame_done_q, frame_done_d;
    logic               last_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            word_cnt_q    <= '0;
            frames_sent_q <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            word_cnt_q    <= word_cnt_d;
            frames_sent_q <= frames_sent_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // rst_n is folded in so no frame can be offered while reset is held.
    assign frame_ready = rst_n && (state_q == IDLE) && !in_collision_state;
    assign last_word   = (word_cnt_q == LAST_IDX);

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        word_cnt_d    = word_cnt_q;
        frames_sent_d = frames_sent_q;
        frame_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_valid && frame_ready) begin
                    shreg_d    = frame_data;
                    word_cnt_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (m_tready) begin
                    shreg_d    = shreg_q << WORD_W;
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    if (last_word) begin
                        state_d       = IDLE;
                        frame_done_d  = 1'b1;
                        frames_sent_d = frames_sent_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_tvalid    = (state_q == SEND);
    assign busy        = (state_q == SEND);
    assign m_tlast     = (state_q == SEND) && last_word;
    assign m_tdata     = shreg_q[DEPTH-1 -: WORD_W];
    assign frame_done  = frame_done_q;
    assign frames_sent = frames_sent_q;

endmodule
